// File: rtl/sid_mixer_seq_if.sv
// Bus bundle for the SID output stage: voice/envelope inputs, filter returns,
// mixed samples and status. master drives the inputs, slave is the mixer.
interface sid_mixer_seq_if #(
    parameter int NUM_VOICES = 3,
    parameter int VOICE_W    = 12,
    parameter int ENV_W      = 8,
    parameter int OUT_W      = 16
);
    logic                           CLKen;
    logic [NUM_VOICES*VOICE_W-1:0]  VOICE_IN;
    logic [NUM_VOICES*ENV_W-1:0]    ENV_IN;
    logic [NUM_VOICES-1:0]          FILT_ROUTE;
    logic [2:0]                     MODE;
    logic [3:0]                     VOLUME;
    logic signed [OUT_W-1:0]        FILT_LP;
    logic signed [OUT_W-1:0]        FILT_BP;
    logic signed [OUT_W-1:0]        FILT_HP;
    logic signed [OUT_W-1:0]        PRE_FILTER;
    logic                           PRE_VALID;
    logic signed [OUT_W-1:0]        OUTPUT;
    logic                           OUT_VALID;
    logic                           BUSY;
    logic                           OVERRUN;

    modport master (
        output CLKen, VOICE_IN, ENV_IN, FILT_ROUTE, MODE, VOLUME, FILT_LP, FILT_BP, FILT_HP,
        input  PRE_FILTER, PRE_VALID, OUTPUT, OUT_VALID, BUSY, OVERRUN
    );
    modport slave (
        input  CLKen, VOICE_IN, ENV_IN, FILT_ROUTE, MODE, VOLUME, FILT_LP, FILT_BP, FILT_HP,
        output PRE_FILTER, PRE_VALID, OUTPUT, OUT_VALID, BUSY, OVERRUN
    );
endinterface

// File: rtl/sid_mixer_seq.sv
// Time-multiplexed SID output stage: one shared multiplier walks the voices, then mix and volume.
// Optional SID_MIXER_VOL_RAMP_EN: volume slews one step per sample toward VOLUME.
module sid_mixer_seq #(
    parameter int NUM_VOICES = 3,
    parameter int VOICE_W    = 12,
    parameter int ENV_W      = 8,
    parameter int OUT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    sid_mixer_seq_if.slave   bus
);
    localparam int PROD_W = VOICE_W + ENV_W;
    localparam int SH     = PROD_W - OUT_W;
    localparam int ACC_W  = OUT_W + 4;
    localparam int SW     = OUT_W + 8;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic signed [SW-1:0] S_MAX = SW'((1 <<< (OUT_W-1)) - 1);
    localparam logic signed [SW-1:0] S_MIN = -S_MAX - 1;

    typedef enum logic [2:0] {IDLE, MUL, DRAIN, MIX, VOL} state_t;
    state_t state, state_nx;

    logic [VOICE_W-1:0]       voice_s [NUM_VOICES];
    logic [ENV_W-1:0]         env_s   [NUM_VOICES];
    logic [NUM_VOICES-1:0]    route_s;
    logic [IDX_W-1:0]         idx;
    logic [VOICE_W-1:0]       v_cur;
    logic [ENV_W-1:0]         e_cur;
    logic signed [VOICE_W-1:0] sv;
    logic signed [PROD_W-1:0] prod_nx, prod_q;
    logic                     prod_vld, route_q;
    logic signed [OUT_W-1:0]  amp;
    logic signed [ACC_W-1:0]  contrib, acc_filt, acc_byp;
    logic signed [SW-1:0]     post_sum, vol_prod;
    logic signed [OUT_W-1:0]  pre_q, post_q, out_q;
    logic                     pre_vld, out_vld, overrun;
    logic [3:0]               vol;

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [SW-1:0] x);
        if (x > S_MAX)      return S_MAX[OUT_W-1:0];
        else if (x < S_MIN) return S_MIN[OUT_W-1:0];
        else                return x[OUT_W-1:0];
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.CLKen) state_nx = MUL;
            MUL:     if (idx == IDX_W'(NUM_VOICES-1)) state_nx = DRAIN;
            DRAIN:   state_nx = MIX;
            MIX:     state_nx = VOL;
            VOL:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Offset-binary voice becomes signed by flipping the MSB before the shared multiply.
    always_comb begin
        v_cur    = voice_s[idx];
        e_cur    = env_s[idx];
        sv       = $signed({~v_cur[VOICE_W-1], v_cur[VOICE_W-2:0]});
        prod_nx  = PROD_W'(sv) * PROD_W'($signed({1'b0, e_cur}));
        amp      = OUT_W'(prod_q >>> SH);
        contrib  = ACC_W'(amp >>> 3);
        post_sum = SW'(acc_byp);
        if (bus.MODE[0]) post_sum = post_sum + SW'(bus.FILT_LP);
        if (bus.MODE[1]) post_sum = post_sum + SW'(bus.FILT_BP);
        if (bus.MODE[2]) post_sum = post_sum + SW'(bus.FILT_HP);
        vol_prod = SW'(post_q) * SW'($signed({1'b0, vol}));
    end

    always_ff @(posedge CLK) begin
        if (!RST && state == IDLE && bus.CLKen) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                voice_s[k] <= bus.VOICE_IN[k*VOICE_W +: VOICE_W];
                env_s[k]   <= bus.ENV_IN[k*ENV_W +: ENV_W];
            end
            route_s <= bus.FILT_ROUTE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx      <= '0;
            prod_q   <= '0;
            prod_vld <= 1'b0;
            route_q  <= 1'b0;
            acc_filt <= '0;
            acc_byp  <= '0;
            pre_q    <= '0;
            post_q   <= '0;
            out_q    <= '0;
            pre_vld  <= 1'b0;
            out_vld  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            pre_vld <= 1'b0;
            out_vld <= 1'b0;
            if (bus.CLKen && state != IDLE) overrun <= 1'b1;
            // Accumulate one stage behind the multiply so MUL and add overlap.
            if (prod_vld) begin
                if (route_q) acc_filt <= acc_filt + contrib;
                else         acc_byp  <= acc_byp + contrib;
            end
            case (state)
                IDLE: if (bus.CLKen) begin
                    acc_filt <= '0;
                    acc_byp  <= '0;
                    idx      <= '0;
                    prod_vld <= 1'b0;
                end
                MUL: begin
                    prod_q   <= prod_nx;
                    route_q  <= route_s[idx];
                    prod_vld <= 1'b1;
                    idx      <= idx + 1'b1;
                end
                DRAIN: prod_vld <= 1'b0;
                MIX: begin
                    pre_q   <= sat(SW'(acc_filt));
                    pre_vld <= 1'b1;
                    post_q  <= sat(post_sum);
                end
                VOL: begin
                    out_q   <= sat(vol_prod >>> 4);
                    out_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SID_MIXER_VOL_RAMP_EN
    logic [3:0] vol_cur;
    always_ff @(posedge CLK) begin
        if (RST) vol_cur <= '0;
        else if (state == VOL) begin
            if (vol_cur < bus.VOLUME)      vol_cur <= vol_cur + 1'b1;
            else if (vol_cur > bus.VOLUME) vol_cur <= vol_cur - 1'b1;
        end
    end
    assign vol = vol_cur;
`else
    assign vol = bus.VOLUME;
`endif

    assign bus.PRE_FILTER = pre_q;
    assign bus.PRE_VALID  = pre_vld;
    assign bus.OUTPUT     = out_q;
    assign bus.OUT_VALID  = out_vld;
    assign bus.BUSY       = (state != IDLE);
    assign bus.OVERRUN    = overrun;
endmodule

// File: tb/tb_sid_mixer_seq.sv
// Bench for sid_mixer_seq: directed corner passes plus random passes against an arithmetic model.
module tb_sid_mixer_seq;
    localparam int NV = 3;
    localparam int VW = 12;
    localparam int EW = 8;
    localparam int OW = 16;
    localparam int SH = VW + EW - OW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   vol_state = 0;

    always #5 clk = ~clk;

    sid_mixer_seq_if #(.NUM_VOICES(NV), .VOICE_W(VW), .ENV_W(EW), .OUT_W(OW)) bus ();
    sid_mixer_seq #(.NUM_VOICES(NV), .VOICE_W(VW), .ENV_W(EW), .OUT_W(OW)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x);
        int hi = (1 << (OW-1)) - 1;
        int lo = -(1 << (OW-1));
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

    // Expected samples from plain integer arithmetic on the currently driven inputs.
    function automatic void model(input int vol, output int pre, output int out);
        int af = 0, ab = 0, sv, prod, post;
        for (int k = 0; k < NV; k++) begin
            sv   = int'(bus.VOICE_IN[k*VW +: VW]) - (1 << (VW-1));
            prod = sv * int'(bus.ENV_IN[k*EW +: EW]);
            if (bus.FILT_ROUTE[k]) af += (prod >>> SH) >>> 3;
            else                   ab += (prod >>> SH) >>> 3;
        end
        if (bus.MODE[0]) ab += int'(bus.FILT_LP);
        if (bus.MODE[1]) ab += int'(bus.FILT_BP);
        if (bus.MODE[2]) ab += int'(bus.FILT_HP);
        pre  = sat(af);
        post = sat(ab);
        out  = sat((post * vol) >>> 4);
    endfunction

    task automatic step_vol();
`ifdef SID_MIXER_VOL_RAMP_EN
        if (vol_state < int'(bus.VOLUME))      vol_state++;
        else if (vol_state > int'(bus.VOLUME)) vol_state--;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.CLKen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vol_state = 0;
    endtask

    task automatic set_in(input logic [11:0] v, input logic [7:0] e, input logic [2:0] r,
                          input logic [2:0] m, input int lp, input int bp, input int hp,
                          input logic [3:0] vol);
        for (int k = 0; k < NV; k++) begin
            bus.VOICE_IN[k*VW +: VW] = v;
            bus.ENV_IN[k*EW +: EW]   = e;
        end
        bus.FILT_ROUTE = r;
        bus.MODE       = m;
        bus.FILT_LP    = OW'(lp);
        bus.FILT_BP    = OW'(bp);
        bus.FILT_HP    = OW'(hp);
        bus.VOLUME     = vol;
    endtask

    task automatic run_pass(input string tag);
        int pre_exp, out_exp, vol_used, pre_at, out_at, busy5;
        pre_at = -1;
        out_at = -1;
        busy5  = -1;
`ifdef SID_MIXER_VOL_RAMP_EN
        vol_used = vol_state;
`else
        vol_used = int'(bus.VOLUME);
`endif
        model(vol_used, pre_exp, out_exp);
        bus.CLKen = 1'b1;
        @(negedge clk);
        bus.CLKen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == NV + 2) busy5 = int'(bus.BUSY);
            if (bus.PRE_VALID && pre_at < 0) pre_at = k;
            if (bus.OUT_VALID) begin
                out_at = k;
                break;
            end
        end
        step_vol();
        chk({tag, ".pre_at"}, pre_at, NV + 2);
        chk({tag, ".out_at"}, out_at, NV + 3);
        chk({tag, ".busy"}, busy5, 1);
        chk({tag, ".pre"}, int'(bus.PRE_FILTER), pre_exp);
        chk({tag, ".out"}, int'(bus.OUTPUT), out_exp);
        @(negedge clk);
        chk({tag, ".out_vld_drop"}, int'(bus.OUT_VALID), 0);
        chk({tag, ".out_hold"}, int'(bus.OUTPUT), out_exp);
        chk({tag, ".idle"}, int'(bus.BUSY), 0);
    endtask

    initial begin
        int nvld;
        rst = 1'b1;
        bus.CLKen = 1'b0;
        set_in(12'hFFF, 8'd255, 3'b000, 3'b000, 0, 0, 0, 4'd15);
        do_reset();
        chk("rst.out", int'(bus.OUTPUT), 0);
        chk("rst.pre", int'(bus.PRE_FILTER), 0);
        chk("rst.busy", int'(bus.BUSY), 0);
        chk("rst.ovr", int'(bus.OVERRUN), 0);
        chk("rst.vld", int'(bus.OUT_VALID) + int'(bus.PRE_VALID), 0);

        run_pass("case1");
        set_in(12'h000, 8'd255, 3'b111, 3'b000, 0, 0, 0, 4'd15);
        run_pass("case2");
        set_in(12'hFFF, 8'd255, 3'b000, 3'b001, 32767, 0, 0, 4'd15);
        run_pass("case3");

        // Overrun: second strobe two edges into the pass.
        set_in(12'hFFF, 8'd255, 3'b000, 3'b000, 0, 0, 0, 4'd15);
        nvld = 0;
        bus.CLKen = 1'b1;
        @(negedge clk);
        bus.CLKen = 1'b0;
        @(negedge clk);
        chk("ovr.busy_e1", int'(bus.BUSY), 1);
        bus.CLKen = 1'b1;
        @(negedge clk);
        bus.CLKen = 1'b0;
        chk("ovr.flag", int'(bus.OVERRUN), 1);
        for (int k = 3; k <= 14; k++) begin
            @(negedge clk);
            if (bus.OUT_VALID) nvld++;
        end
        step_vol();
        chk("ovr.one_pulse", nvld, 1);
        chk("ovr.idle", int'(bus.BUSY), 0);
        run_pass("ovr.next");
        chk("ovr.sticky", int'(bus.OVERRUN), 1);
        do_reset();
        chk("ovr.cleared", int'(bus.OVERRUN), 0);

        // Leave non-zero outputs, then reset at E3 of the following pass.
        run_pass("abort.pre");
        set_in(12'hFFF, 8'd255, 3'b101, 3'b000, 0, 0, 0, 4'd15);
        bus.CLKen = 1'b1;
        @(negedge clk);
        bus.CLKen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vol_state = 0;
        nvld = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nvld += int'(bus.OUT_VALID) + int'(bus.PRE_VALID);
        end
        chk("abort.no_vld", nvld, 0);
        chk("abort.out", int'(bus.OUTPUT), 0);
        chk("abort.pre", int'(bus.PRE_FILTER), 0);
        chk("abort.busy", int'(bus.BUSY), 0);
        set_in(12'hFFF, 8'd255, 3'b000, 3'b000, 0, 0, 0, 4'd15);
        run_pass("abort.after");

        // Repeated passes from reset (volume ramp when enabled).
        do_reset();
        for (int p = 0; p < 16; p++) run_pass($sformatf("ramp%0d", p));

        for (int p = 0; p < 25; p++) begin
            for (int k = 0; k < NV; k++) begin
                bus.VOICE_IN[k*VW +: VW] = VW'($urandom_range(0, 4095));
                bus.ENV_IN[k*EW +: EW]   = ($urandom_range(0, 7) == 0) ? 8'd0 : EW'($urandom_range(0, 255));
            end
            bus.FILT_ROUTE = NV'($urandom_range(0, 7));
            bus.MODE       = 3'($urandom_range(0, 7));
            bus.FILT_LP    = OW'($urandom_range(0, 65535));
            bus.FILT_BP    = OW'($urandom_range(0, 65535));
            bus.FILT_HP    = OW'($urandom_range(0, 65535));
            bus.VOLUME     = 4'($urandom_range(0, 15));
            run_pass($sformatf("rand%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
